at24c04_eeprom: RTL and testbench



---
 rtl/at24c04_eeprom.sv | 199 +++++++++++++++++++
 tb/tb_at24c04_eeprom.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/at24c04_eeprom.sv
// 512 x 8 I2C serial EEPROM slave (AT24C04 behaviour), SCL/SDA oversampled on clk_i.
// Supports byte/page write with write protect, current/random/sequential read and ACK polling.
module at24c04_eeprom #(
  parameter logic [3:0]  DEV_TYPE   = 4'b1010,
  parameter logic [1:0]  PIN_A2A1   = 2'b00,
  parameter int unsigned PAGE_BYTES = 16,
  parameter int unsigned TWR_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe_o,
  input  logic wp_i,
  output logic busy_o
);

  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned PAGE_W    = $clog2(PAGE_BYTES);
  localparam int unsigned TWR_W     = $clog2(TWR_CYCLES + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV, ST_DEV_ACK, ST_WADDR, ST_WADDR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RD_MACK, ST_BUSY
  } state_t;

  logic [7:0] r_mem [MEM_DEPTH] = '{default: 8'hFF};
  logic [7:0] r_pbuf [PAGE_BYTES];

  logic                  r_scl_s1, r_scl_s2, r_scl_d;
  logic                  r_sda_s1, r_sda_s2, r_sda_d;
  state_t                r_state;
  logic                  r_sda_oe, r_busy;
  logic [ADDR_W-1:0]     r_addr;
  logic [PAGE_BYTES-1:0] r_pvalid;
  logic [PAGE_W-1:0]     r_commit_idx;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  r_ack_on, r_mack, r_rw, r_have_data;
  logic [TWR_W-1:0]      r_twr;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_dev_match, w_mem_we;
  logic [7:0] w_byte, w_rd_byte;

  // Pad synchronizers plus one delayed copy for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda_i; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise  = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall  = ~r_scl_s2 & r_scl_d;
  assign w_start     = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop      = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte      = {r_shift[6:0], r_sda_s2};
  assign w_dev_match = (w_byte[7:4] == DEV_TYPE) && (w_byte[3:2] == PIN_A2A1) && !r_busy;
  assign w_rd_byte   = r_mem[r_addr];
  assign w_mem_we    = !rst_i && (r_state == ST_BUSY) && r_pvalid[r_commit_idx];

  // Page buffer drains into the array one byte per clock during the write cycle
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[{r_addr[ADDR_W-1:PAGE_W], r_commit_idx}] <= r_pbuf[r_commit_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_sda_oe     <= 1'b0;
      r_busy       <= 1'b0;
      r_addr       <= '0;
      r_pvalid     <= '0;
      r_commit_idx <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_ack_on     <= 1'b0;
      r_mack       <= 1'b0;
      r_rw         <= 1'b0;
      r_have_data  <= 1'b0;
      r_twr        <= '0;
    end else if (r_state == ST_BUSY) begin
      // Bus activity is ignored here, so a DEV byte simply sees no ACK
      r_pvalid[r_commit_idx] <= 1'b0;
      r_commit_idx <= r_commit_idx + PAGE_W'(1);
      if (r_twr == '0) begin
        r_busy  <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        r_twr <= r_twr - TWR_W'(1);
      end
    end else if (w_start) begin
      r_state     <= ST_DEV;
      r_bit_cnt   <= '0;
      r_sda_oe    <= 1'b0;
      r_ack_on    <= 1'b0;
      r_pvalid    <= '0;
      r_have_data <= 1'b0;
    end else if (w_stop) begin
      r_sda_oe    <= 1'b0;
      r_ack_on    <= 1'b0;
      r_have_data <= 1'b0;
      if (r_have_data && !wp_i) begin
        r_state      <= ST_BUSY;
        r_busy       <= 1'b1;
        r_twr        <= TWR_W'(TWR_CYCLES - 1);
        r_commit_idx <= '0;
      end else begin
        r_state  <= ST_IDLE;
        r_pvalid <= '0;
      end
    end else begin
      case (r_state)
        ST_DEV, ST_WADDR, ST_WDATA: begin
          if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_state == ST_DEV) begin
                if (w_dev_match) begin
                  r_state        <= ST_DEV_ACK;
                  r_rw           <= w_byte[0];
                  r_addr[ADDR_W-1] <= w_byte[1];
                end else begin
                  r_state <= ST_IDLE;
                end
              end else if (r_state == ST_WADDR) begin
                r_addr[7:0] <= w_byte;
                r_state     <= ST_WADDR_ACK;
              end else begin
                r_pbuf[r_addr[PAGE_W-1:0]]   <= w_byte;
                r_pvalid[r_addr[PAGE_W-1:0]] <= 1'b1;
                r_addr[PAGE_W-1:0]           <= r_addr[PAGE_W-1:0] + PAGE_W'(1);
                r_have_data                  <= 1'b1;
                r_state                      <= ST_WDATA_ACK;
              end
            end
          end
        end
        // First SCL fall starts the ACK slot, second one ends it
        ST_DEV_ACK, ST_WADDR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              r_ack_on <= 1'b1;
              r_sda_oe <= 1'b1;
            end else begin
              r_ack_on  <= 1'b0;
              r_bit_cnt <= '0;
              if (r_state == ST_DEV_ACK && r_rw) begin
                r_state  <= ST_RDATA;
                r_shift  <= w_rd_byte;
                r_sda_oe <= ~w_rd_byte[7];
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= (r_state == ST_DEV_ACK) ? ST_WADDR : ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              r_sda_oe <= 1'b0;
              r_addr   <= r_addr + ADDR_W'(1);
              r_state  <= ST_RD_MACK;
            end else begin
              r_shift   <= {r_shift[6:0], r_shift[7]};
              r_sda_oe  <= ~r_shift[6];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_RD_MACK: begin
          if (w_scl_rise) r_mack <= ~r_sda_s2;
          if (w_scl_fall) begin
            r_bit_cnt <= '0;
            if (r_mack) begin
              r_state  <= ST_RDATA;
              r_shift  <= w_rd_byte;
              r_sda_oe <= ~w_rd_byte[7];
            end else begin
              r_state  <= ST_IDLE;
              r_sda_oe <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe_o = r_sda_oe;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_at24c04_eeprom.sv
// Bench for at24c04_eeprom: bit-level I2C master against a byte-array model of the EEPROM.
module tb_at24c04_eeprom;

  localparam int unsigned TWR = 600;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic wp    = 1'b0;
  logic sda_oe, busy, sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  at24c04_eeprom #(.TWR_CYCLES(TWR)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe_o(sda_oe), .wp_i(wp), .busy_o(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_mem [512];
  logic [8:0] m_addr = '0;
  logic [7:0] wq [$];
  logic [7:0] rd_buf [16];
  logic       ack;
  logic [7:0] rx;

  // Length of the most recent busy pulse in clocks
  logic busy_q   = 1'b0;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    busy_q <= busy;
    if (busy && !busy_q) busy_cnt <= 1;
    else if (busy)       busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(4); scl_m = 1'b1; tick(8); scl_m = 1'b0; tick(4);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; tick(4); scl_m = 1'b1; tick(4); b = sda_line; tick(4); scl_m = 1'b0; tick(4);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(4); scl_m = 1'b1; tick(8); sda_m = 1'b0; tick(8); scl_m = 1'b0; tick(4);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; tick(4); scl_m = 1'b1; tick(8); sda_m = 1'b1; tick(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(s);
    a = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(s);
      d[i] = s;
    end
    send_bit(~mack);
  endtask

  // Model: page roll-over inside the 16-byte page, pointer ends one past the last byte
  task automatic model_write(input logic p0, input logic [7:0] word, input logic wpv);
    int base, off, n;
    base = int'({p0, word[7:4]}) * 16;
    off  = int'(word[3:0]);
    n    = wq.size();
    if (!wpv) for (int i = 0; i < n; i++) m_mem[base + (off + i) % 16] = wq[i];
    m_addr = 9'(base + (off + n) % 16);
  endtask

  task automatic do_write(input logic p0, input logic [7:0] word, input logic wpv);
    wp = wpv;
    i2c_start;
    write_byte({4'hA, 2'b00, p0, 1'b0}, ack); check("wr_dev_ack", 16'(ack), 16'd1);
    write_byte(word, ack);                    check("wr_word_ack", 16'(ack), 16'd1);
    foreach (wq[i]) begin
      write_byte(wq[i], ack);                 check("wr_data_ack", 16'(ack), 16'd1);
    end
    i2c_stop;
    model_write(p0, word, wpv);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 4 * TWR) begin
      @(negedge clk);
      n++;
    end
    check("busy_clears", 16'(busy), 16'd0);
  endtask

  task automatic read_seq(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, rx);
      rd_buf[i] = rx;
      check(tag, 16'(rx), 16'(m_mem[m_addr]));
      m_addr = m_addr + 9'd1;
    end
    i2c_stop;
  endtask

  task automatic rand_read(input logic p0, input logic [7:0] word, input int n, input string tag);
    i2c_start;
    write_byte({4'hA, 2'b00, p0, 1'b0}, ack); check("rr_wdev_ack", 16'(ack), 16'd1);
    write_byte(word, ack);                    check("rr_word_ack", 16'(ack), 16'd1);
    i2c_start;
    write_byte({4'hA, 2'b00, p0, 1'b1}, ack); check("rr_rdev_ack", 16'(ack), 16'd1);
    m_addr = {p0, word};
    read_seq(n, tag);
  endtask

  task automatic cur_read(input logic p0, input int n, input string tag);
    i2c_start;
    write_byte({4'hA, 2'b00, p0, 1'b1}, ack); check("cr_dev_ack", 16'(ack), 16'd1);
    m_addr[8] = p0;
    read_seq(n, tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] ra [6];
    logic [7:0] d;
    for (int i = 0; i < 512; i++) m_mem[i] = 8'hFF;

    // Reset
    tick(6);
    check("rst_sda_oe", 16'(sda_oe), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    tick(10);

    // Current-address read after reset: address 0x000
    cur_read(1'b0, 1, "reset_cur_read");
    check("reset_byte_const", 16'(rd_buf[0]), 16'h00FF);

    // Wrong device type: NACK, slave back in IDLE
    i2c_start;
    write_byte(8'hB0, ack);
    check("wrong_dev_nack", 16'(ack), 16'd0);
    check("wrong_dev_sda_rel", 16'(sda_oe), 16'd0);
    i2c_stop;

    // Byte write, busy duration and ACK polling
    wq = {8'h5A};
    do_write(1'b0, 8'h10, 1'b0);
    check("busy_after_stop", 16'(busy), 16'd1);
    i2c_start;
    write_byte(8'hA0, ack);
    check("poll_busy_nack", 16'(ack), 16'd0);
    i2c_stop;
    wait_idle;
    check("busy_len", 16'(busy_cnt), 16'(TWR));
    i2c_start;
    write_byte(8'hA0, ack);
    check("poll_idle_ack", 16'(ack), 16'd1);
    i2c_stop;
    m_addr[8] = 1'b0;
    check("dev_only_no_busy", 16'(busy), 16'd0);
    rand_read(1'b0, 8'h10, 1, "byte_write_rd");
    check("byte_write_const", 16'(rd_buf[0]), 16'h005A);

    // 18-byte page write wraps inside the page
    wq = {};
    for (int i = 0; i < 18; i++) wq.push_back(8'(i));
    do_write(1'b0, 8'h20, 1'b0);
    wait_idle;
    rand_read(1'b0, 8'h20, 16, "page_rd");
    check("page_0x20", 16'(rd_buf[0]), 16'h0010);
    check("page_0x21", 16'(rd_buf[1]), 16'h0011);
    check("page_0x22", 16'(rd_buf[2]), 16'h0002);
    check("page_0x2f", 16'(rd_buf[15]), 16'h000F);

    // Write protect: ACKed, discarded, no write cycle
    wq = {8'h33};
    do_write(1'b0, 8'h05, 1'b1);
    check("wp_no_busy", 16'(busy), 16'd0);
    tick(50);
    check("wp_no_busy_later", 16'(busy), 16'd0);
    wp = 1'b0;
    rand_read(1'b0, 8'h05, 1, "wp_rd");

    // Random byte writes across the whole array
    for (int k = 0; k < 6; k++) begin
      ra[k] = 9'($urandom_range(0, 511));
      wq = {8'($urandom)};
      do_write(ra[k][8], ra[k][7:0], 1'b0);
      wait_idle;
    end
    wq = {8'($urandom), 8'($urandom)};
    do_write(1'b1, 8'hFE, 1'b0);
    wait_idle;
    wq = {8'($urandom)};
    do_write(1'b0, 8'h00, 1'b0);
    wait_idle;

    // Sequential read across the top of the array
    rand_read(1'b1, 8'hFE, 3, "seq_wrap_rd");
    check("seq_wrap_addr", 16'(m_addr), 16'h0001);
    for (int k = 0; k < 6; k++) rand_read(ra[k][8], ra[k][7:0], 2, "rand_rd");

    // STOP right after the word address keeps the address
    i2c_start;
    write_byte(8'hA0, ack); check("addr_only_dev_ack", 16'(ack), 16'd1);
    write_byte(8'h40, ack); check("addr_only_word_ack", 16'(ack), 16'd1);
    i2c_stop;
    check("addr_only_no_busy", 16'(busy), 16'd0);
    m_addr = 9'h040;
    cur_read(1'b0, 1, "addr_only_cur_rd");

    // Repeated START aborts a buffered write
    d = m_mem[9'h050] ^ 8'($urandom_range(1, 255));
    i2c_start;
    write_byte(8'hA0, ack); check("abort_dev_ack", 16'(ack), 16'd1);
    write_byte(8'h50, ack); check("abort_word_ack", 16'(ack), 16'd1);
    write_byte(d, ack);     check("abort_data_ack", 16'(ack), 16'd1);
    m_addr = 9'h051;
    i2c_start;
    write_byte(8'hA1, ack); check("abort_rdev_ack", 16'(ack), 16'd1);
    read_seq(1, "abort_cur_rd");
    check("abort_no_busy", 16'(busy), 16'd0);
    rand_read(1'b0, 8'h50, 1, "abort_unchanged");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
